// File: rtl/car_drive_unit.sv
// Car and door actuator model: turns engine/door commands into floor-arrival and door-position
// sensor feedback, and latches a sticky fault on any illegal command.
module car_drive_unit #(
  parameter int FLOORS        = 8,
  parameter int TRAVEL_CYCLES = 40,
  parameter int DOOR_CYCLES   = 20,
  parameter int START_FLOOR   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                engine,
  input  logic [1:0]                door,
  output logic                      sensor_up,
  output logic                      sensor_down,
  output logic [1:0]                sensor_door,
  output logic [$clog2(FLOORS)-1:0] floor,
  output logic                      fault
);

  localparam int FW = $clog2(FLOORS);
  localparam int TW = $clog2(TRAVEL_CYCLES);
  localparam int DW = $clog2(DOOR_CYCLES + 1);

  localparam logic [FW-1:0] FLOOR_TOP   = FW'(FLOORS - 1);
  localparam logic [FW-1:0] FLOOR_START = FW'(START_FLOOR);
  localparam logic [TW-1:0] T_LAST      = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE       = TW'(1);
  localparam logic [DW-1:0] D_FULL      = DW'(DOOR_CYCLES);

  localparam logic [1:0] ENG_STOP = 2'b00;
  localparam logic [1:0] ENG_UP   = 2'b01;
  localparam logic [1:0] ENG_DOWN = 2'b10;
  localparam logic [1:0] ENG_BAD  = 2'b11;
  localparam logic [1:0] DOOR_OPEN  = 2'b01;
  localparam logic [1:0] DOOR_CLOSE = 2'b10;

  logic [FW-1:0] floor_q, floor_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          up_q, up_d;
  logic          down_q, down_d;
  logic [1:0]    sdoor_q, sdoor_d;
  logic          fault_q, fault_d;

  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
    return (v == D_FULL) ? v : v + 1'b1;
  endfunction

  function automatic logic [DW-1:0] sat_dec(input logic [DW-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  always_comb begin
    floor_d = floor_q;
    tcnt_d  = tcnt_q;
    dcnt_d  = dcnt_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
    fault_d = fault_q;

    // Motion interlock: any engine command with the door not fully closed is refused.
    if (engine != ENG_STOP && dcnt_q != '0) begin
      fault_d = 1'b1;
    end else begin
      case (engine)
        ENG_UP: begin
          if (tcnt_q == '0 && floor_q == FLOOR_TOP) begin
            fault_d = 1'b1;
          end else if (tcnt_q == T_LAST) begin
            floor_d = floor_q + 1'b1;
            tcnt_d  = '0;
            up_d    = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        ENG_DOWN: begin
          if (tcnt_q == '0) begin
            if (floor_q == '0) begin
              fault_d = 1'b1;
            end else begin
              floor_d = floor_q - 1'b1;
              tcnt_d  = T_LAST;
            end
          end else begin
            tcnt_d = tcnt_q - 1'b1;
            down_d = (tcnt_q == T_ONE);
          end
        end
        ENG_BAD: fault_d = 1'b1;
        default: ;
      endcase
    end

    // Door uses pre-edge tcnt, so a stroke cannot start on the edge a move begins or ends.
    case (door)
      DOOR_OPEN: begin
        if (tcnt_q == '0 && engine == ENG_STOP) begin
          dcnt_d = sat_inc(dcnt_q);
        end else begin
          fault_d = 1'b1;
        end
      end
      DOOR_CLOSE: dcnt_d = sat_dec(dcnt_q);
      default: ;
    endcase

    sdoor_d = (dcnt_d == '0)     ? 2'b10 :
              (dcnt_d == D_FULL) ? 2'b01 : 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      floor_q <= FLOOR_START;
      tcnt_q  <= '0;
      dcnt_q  <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      sdoor_q <= 2'b10;
      fault_q <= 1'b0;
    end else begin
      floor_q <= floor_d;
      tcnt_q  <= tcnt_d;
      dcnt_q  <= dcnt_d;
      up_q    <= up_d;
      down_q  <= down_d;
      sdoor_q <= sdoor_d;
      fault_q <= fault_d;
    end
  end

  assign sensor_up   = up_q;
  assign sensor_down = down_q;
  assign sensor_door = sdoor_q;
  assign floor       = floor_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_car_drive_unit.sv
// Scoreboard bench for car_drive_unit: a position-in-ticks reference model predicts every
// registered output; a monitor pops one prediction per clock edge or reset assertion.
module tb_car_drive_unit;

  localparam int FL = 8;
  localparam int TC = 4;
  localparam int DC = 3;
  localparam int SF = 0;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic [1:0] engine = 2'b00;
  logic [1:0] door   = 2'b00;
  logic       sensor_up;
  logic       sensor_down;
  logic [1:0] sensor_door;
  logic [2:0] floor;
  logic       fault;

  car_drive_unit #(
    .FLOORS(FL), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC), .START_FLOOR(SF)
  ) dut (
    .clk(clk), .reset(reset), .engine(engine), .door(door),
    .sensor_up(sensor_up), .sensor_down(sensor_down), .sensor_door(sensor_door),
    .floor(floor), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       up;
    logic       dn;
    logic [1:0] sd;
    logic [2:0] fl;
    logic       flt;
    int         id;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: car position measured in travel ticks from floor 0, door in stroke ticks.
  int m_pos   = SF * TC;
  int m_door  = 0;
  bit m_fault = 1'b0;
  int n_id    = 0;
  int n_chk   = 0;
  int n_fail  = 0;

  function automatic void push(input bit up, input bit dn);
    exp_t e;
    e.up  = up;
    e.dn  = dn;
    e.sd  = (m_door == 0) ? 2'b10 : (m_door == DC) ? 2'b01 : 2'b00;
    e.fl  = 3'(m_pos / TC);
    e.flt = m_fault;
    e.id  = n_id;
    n_id++;
    exp_q.push_back(e);
  endfunction

  function automatic void chk(input string nm, input int id, input logic [7:0] got,
                              input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s (event %0d): got %0d, expected %0d", nm, id, got, want);
    end
  endfunction

  task automatic step(input logic [1:0] eng, input logic [1:0] dr);
    bit up, dn, nf;
    int np, nd;
    @(negedge clk);
    reset  = 1'b1;
    engine = eng;
    door   = dr;
    up = 1'b0; dn = 1'b0; np = m_pos; nd = m_door; nf = m_fault;
    if (eng != 2'd0) begin
      if (m_door != 0 || eng == 2'd3) nf = 1'b1;
      else if (eng == 2'd1) begin
        if (m_pos == (FL - 1) * TC) nf = 1'b1;
        else begin np = m_pos + 1; up = (np % TC == 0); end
      end else begin
        if (m_pos == 0) nf = 1'b1;
        else begin np = m_pos - 1; dn = (np % TC == 0); end
      end
    end
    if (dr == 2'd1) begin
      if (m_pos % TC == 0 && eng == 2'd0) nd = (m_door < DC) ? m_door + 1 : DC;
      else nf = 1'b1;
    end else if (dr == 2'd2) begin
      nd = (m_door > 0) ? m_door - 1 : 0;
    end
    m_pos = np; m_door = nd; m_fault = nf;
    push(up, dn);
  endtask

  task automatic hold(input logic [1:0] eng, input logic [1:0] dr, input int n);
    repeat (n) step(eng, dr);
  endtask

  // Asserts reset between clock edges so the checked values can only come from the async path.
  task automatic do_reset();
    @(negedge clk);
    engine = 2'b00;
    door   = 2'b00;
    m_pos = SF * TC; m_door = 0; m_fault = 1'b0;
    push(1'b0, 1'b0);
    reset = 1'b0;
    #2;
    push(1'b0, 1'b0);
  endtask

  always @(posedge clk or negedge reset) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sensor_up",   e.id, 8'(sensor_up),   8'(e.up));
      chk("sensor_down", e.id, 8'(sensor_down), 8'(e.dn));
      chk("sensor_door", e.id, 8'(sensor_door), 8'(e.sd));
      chk("floor",       e.id, 8'(floor),       8'(e.fl));
      chk("fault",       e.id, 8'(fault),       8'(e.flt));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [1:0] eng, dr;

    do_reset();
    // Climb two floors, then stop.
    hold(2'b01, 2'b00, 8);
    hold(2'b00, 2'b00, 2);
    // Drop into the shaft below and come back up.
    step(2'b10, 2'b00);
    step(2'b01, 2'b00);
    step(2'b00, 2'b00);
    // Full open and close strokes, with saturation at both ends.
    hold(2'b00, 2'b01, 4);
    hold(2'b00, 2'b10, 4);
    // Motion while open is refused; fault is sticky.
    hold(2'b00, 2'b01, 3);
    step(2'b01, 2'b00);
    step(2'b00, 2'b00);
    step(2'b00, 2'b11);
    step(2'b00, 2'b10);
    step(2'b01, 2'b10);
    step(2'b00, 2'b10);
    step(2'b01, 2'b00);

    // Top-floor boundary.
    do_reset();
    hold(2'b01, 2'b00, (FL - 1) * TC);
    step(2'b01, 2'b00);
    step(2'b00, 2'b00);

    // Bottom-floor boundary, then opening mid-shaft.
    do_reset();
    step(2'b10, 2'b00);
    step(2'b00, 2'b00);
    do_reset();
    hold(2'b01, 2'b00, 2);
    step(2'b00, 2'b01);
    step(2'b00, 2'b00);

    // Mid-shaft reversal returns with a down pulse; illegal engine code.
    do_reset();
    hold(2'b01, 2'b00, 2);
    hold(2'b10, 2'b00, 2);
    step(2'b00, 2'b00);
    step(2'b11, 2'b00);

    // Reset while mid-shaft between floors 3 and 4.
    do_reset();
    hold(2'b01, 2'b00, 3 * TC + 2);
    do_reset();
    hold(2'b00, 2'b00, 2);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end else begin
        r   = $urandom_range(0, 19);
        eng = (r < 8) ? 2'b00 : (r < 14) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
        r   = $urandom_range(0, 19);
        dr  = (r < 10) ? 2'b00 : (r < 14) ? 2'b01 : (r < 18) ? 2'b10 : 2'b11;
        step(eng, dr);
      end
    end

    hold(2'b00, 2'b00, 2);
    @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
